// File: rtl/sram_bus_responder.sv
// Responder that serves K8088 byte bus cycles from an asynchronous 8-bit SRAM. It paces the
// core with a single-clock ce pulse. Optional one-entry read cache: define LAST_READ_CACHE_EN.
module sram_bus_responder #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [19:0] address,
  input  logic [7:0]  out,
  input  logic        we,
  output logic [7:0]  in,
  output logic        ce,
  output logic [19:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StAccess, StStrobe} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;
  logic [7:0]  in_q, in_d;

`ifdef LAST_READ_CACHE_EN
  logic        valid_q, valid_d;
  logic [19:0] tag_q, tag_d;
  logic [7:0]  data_q, data_d;
  logic        hit;

  assign hit = !we && valid_q && (tag_q == address);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    we_d    = we_q;
    in_d    = in_q;
`ifdef LAST_READ_CACHE_EN
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
`endif
    case (state_q)
      StIdle: begin
        if (!stall) begin
          addr_d  = address;
          dout_d  = out;
          we_d    = we;
          cnt_d   = WaitInit;
          state_d = StAccess;
`ifdef LAST_READ_CACHE_EN
          // Read hit skips the SRAM entirely and strobes on the next clock.
          if (hit) begin
            in_d    = data_q;
            state_d = StStrobe;
          end
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          in_d    = we_q ? dout_q : sram_din;
          state_d = StStrobe;
`ifdef LAST_READ_CACHE_EN
          if (!we_q) begin
            valid_d = 1'b1;
            tag_d   = addr_q;
            data_d  = sram_din;
          end else if (valid_q && (tag_q == addr_q)) begin
            data_d = dout_q;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      dout_q  <= 8'd0;
      we_q    <= 1'b0;
      in_q    <= 8'd0;
`ifdef LAST_READ_CACHE_EN
      valid_q <= 1'b0;
      tag_q   <= 20'd0;
      data_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      in_q    <= in_d;
`ifdef LAST_READ_CACHE_EN
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
`endif
    end
  end

  // SRAM strobes are decoded from registered state so they are only active in ACCESS.
  assign ce        = (state_q == StStrobe);
  assign in        = in_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_ce_n = (state_q != StAccess);
  assign sram_oe_n = !((state_q == StAccess) && !we_q);
  assign sram_we_n = !((state_q == StAccess) && we_q);

endmodule

// File: tb/tb_sram_bus_responder.sv
// Scoreboard bench for sram_bus_responder: the driver queues expected read data per access,
// and a negedge monitor checks it on every ce pulse. An asynchronous SRAM model backs the pins.
module tb_sram_bus_responder;

  localparam int unsigned W = 2;
`ifdef LAST_READ_CACHE_EN
  localparam bit Cache = 1'b1;
`else
  localparam bit Cache = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [19:0] address;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  in;
  logic        ce;
  logic [19:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [logic [19:0]];
  logic ce_prev = 1'b0;

  sram_bus_responder #(.WAIT_STATES(W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .address(address), .out(out), .we(we),
    .in(in), .ce(ce), .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model: read data settles mid-cycle, write lands on the clock edge.
  always @(negedge clock) begin
    if (!sram_ce_n && !sram_oe_n && mem.exists(sram_addr)) sram_din = mem[sram_addr];
    else sram_din = 8'hFF;
  end
  always @(posedge clock) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ce pulse consumes one expected read-data entry.
  always @(negedge clock) begin
    if (reset) begin
      ce_prev = 1'b0;
    end else begin
      if (ce) begin
        if (ce_prev) begin
          n_cmp++; n_err++;
          $display("FAIL ce_double: got ce high 2 clks expected 1");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ce_unexpected: got in=%0h expected no ce", in);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (in !== e) begin
            n_err++;
            $display("FAIL in_data: got %0h expected %0h", in, e);
          end
        end
      end
      ce_prev = ce;
    end
  end

  // Called at #1 after an edge with the DUT idle and stall=1.
  task automatic access(input logic [19:0] a, input logic [7:0] d, input logic w,
                        input logic [7:0] exp_in, input int exp_lat, input int exp_acc);
    int k, strb, cel, wrong;
    bit stable;
    address = a; out = d; we = w; stall = 1'b0;
    exp_q.push_back(exp_in);
    @(posedge clock); #1;
    stall = 1'b1;
    address = ~a; out = ~d; we = ~w;
    k = 1; strb = 0; cel = 0; wrong = 0; stable = 1'b1;
    while (!ce && k < 40) begin
      if (!sram_ce_n) begin
        cel++;
        if (sram_addr !== a || (w && sram_dout !== d)) stable = 1'b0;
      end
      if (w ? !sram_we_n : !sram_oe_n) strb++;
      if (w ? !sram_oe_n : !sram_we_n) wrong++;
      @(posedge clock); #1;
      k++;
    end
    check("ce_latency", k, exp_lat);
    check("strobe_cycles", strb, exp_acc);
    check("sram_ce_cycles", cel, exp_acc);
    check("other_strobe_quiet", wrong, 0);
    check("addr_data_stable", stable, 1);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; address = '0; out = '0; we = 1'b0;
    mem[20'h12345] = 8'hA5;
    mem[20'h00100] = 8'h5A;

    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("reset_idle", {ce, in, sram_ce_n, sram_oe_n, sram_we_n}, {1'b0, 8'h00, 3'b111});
    end
    reset = 1'b0;
    @(posedge clock); #1;

    access(20'h12345, 8'h00, 1'b0, 8'hA5, W + 2, W + 1);
    access(20'hFFFF0, 8'hEA, 1'b1, 8'hEA, W + 2, W + 1);
    access(20'hFFFF0, 8'h00, 1'b0, 8'hEA, W + 2, W + 1);

    address = 20'h12345; we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("stall_hold", {ce, sram_ce_n}, 2'b01);
    end
    access(20'h12345, 8'h00, 1'b0, 8'hA5, W + 2, W + 1);

    // Abort a write on its second ACCESS clock.
    address = 20'h00200; out = 8'h77; we = 1'b1; stall = 1'b0;
    @(posedge clock); #1;
    stall = 1'b1;
    @(posedge clock); #1;
    check("abort_we_low", sram_we_n, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_released", {ce, sram_ce_n, sram_we_n}, 3'b011);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("abort_no_ce", {ce, sram_ce_n}, 2'b01);
    end

    access(20'h00100, 8'h00, 1'b0, 8'h5A, W + 2, W + 1);
    access(20'h00100, 8'h00, 1'b0, 8'h5A, Cache ? 1 : W + 2, Cache ? 0 : W + 1);
    access(20'h00100, 8'h3C, 1'b1, 8'h3C, W + 2, W + 1);
    access(20'h00100, 8'h00, 1'b0, 8'h3C, Cache ? 1 : W + 2, Cache ? 0 : W + 1);
    access(20'h00101, 8'h11, 1'b1, 8'h11, W + 2, W + 1);
    access(20'h00100, 8'h00, 1'b0, 8'h3C, Cache ? 1 : W + 2, Cache ? 0 : W + 1);
    access(20'h00101, 8'h00, 1'b0, 8'h11, W + 2, W + 1);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
